// File: rtl/ones_pattern_gen.sv
// Pattern source for the 7-input ones-counter: for a requested count k, emits
// every WIDTH-bit word with exactly k bits set, in ascending order, one per handshake.
module ones_pattern_gen #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CW-1:0]    count,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             last,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] all_ones;
   logic [WIDTH-1:0] top_mask;
   logic             match;

   function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

   // Largest word with k ones (k ones packed at the top) marks the final pattern.
   assign all_ones = '1;
   assign top_mask = ~(all_ones >> k_q);
   assign match    = (popcount(cand_q) == k_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         cand_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cand_q  <= cand_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cand_d  = cand_q;
      word_d  = word_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               k_d     = count;
               cand_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (match) begin
               word_d  = cand_q;
               valid_d = 1'b1;
               last_d  = (cand_q == top_mask);
               state_d = HOLD;
            end else begin
               cand_d = cand_q + 1'b1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cand_d  = cand_q + 1'b1;
                  state_d = SCAN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_word  = word_q;
   assign last      = last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Scoreboard bench for ones_pattern_gen: expected words are queued at start,
// a negedge monitor pops and compares on every handshake.
module tb_ones_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] count = '0;
   logic       busy;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [6:0] out_word;
   logic       last;
   logic       done;

   always #5 clk = ~clk;

   ones_pattern_gen #(.WIDTH(7), .CW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .count     (count),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .last      (last),
      .done      (done)
   );

   typedef struct {
      logic [6:0] word;
      logic       last;
      int         k;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rdy_mode = 0;
   int   hs_cnt = 0;
   int   sweep_on = 0;
   int   seen[128];

   logic [6:0] last_tbl[8] = '{7'h00, 7'h40, 7'h60, 7'h70, 7'h78, 7'h7C, 7'h7E, 7'h7F};
   int         binom[8]    = '{1, 7, 21, 35, 35, 21, 7, 1};
   logic [6:0] k1_words[7] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                               7'b0010000, 7'b0100000, 7'b1000000};

   // monitor state
   logic       pv = 1'b0, phs = 1'b0, plast = 1'b0, edn = 1'b0, hs;
   logic [6:0] pw = '0;
   exp_t       e;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic push_k(input int k);
      exp_t x;
      if (k == 1) begin
         for (int i = 0; i < 7; i++) begin
            x.word = k1_words[i];
            x.last = (i == 6);
            x.k    = 1;
            exp_q.push_back(x);
         end
      end else begin
         for (int v = 0; v < 128; v++) begin
            if ($countones(v[6:0]) == k) begin
               x.word = v[6:0];
               x.last = (v[6:0] == last_tbl[k]);
               x.k    = k;
               exp_q.push_back(x);
            end
         end
      end
   endtask

   task automatic run_k(input int k, input bit inject);
      int base, lat, got, dn;
      push_k(k);
      base  = hs_cnt;
      lat   = 0;
      got   = 0;
      count = 3'(k);
      start = 1'b1;
      for (int n = 1; n <= 300 && got == 0; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) start = 1'b0;
         if (inject && (n == 10 || n == 60)) begin
            start = 1'b1;
            count = 3'd3;
         end else if (inject && (n == 11 || n == 61)) begin
            start = 1'b0;
            count = 3'(k);
         end
         if (out_valid) begin
            got = 1;
            lat = n;
         end
      end
      start = 1'b0;
      chk($sformatf("latency_k%0d", k), lat, (1 << k) + 1);
      dn = 0;
      for (int n = 0; n < 4000 && dn == 0; n++) begin
         @(negedge clk);
         if (done) dn = 1;
      end
      chk($sformatf("done_seen_k%0d", k), dn, 1);
      chk($sformatf("words_k%0d", k), hs_cnt - base, binom[k]);
      chk($sformatf("queue_left_k%0d", k), exp_q.size(), 0);
      exp_q.delete();
   endtask

   // out_ready driver: always ready, random backpressure, or stalled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv  = 1'b0;
            phs = 1'b0;
            edn = 1'b0;
         end else begin
            if (edn || done) begin
               chk("done_pulse", done, edn);
               if (edn) chk("busy_after_done", busy, 0);
            end
            if (out_valid && pv && !phs) begin
               chk("hold_word", out_word, pw);
               chk("hold_last", last, plast);
            end
            hs = out_valid && out_ready;
            if (hs) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_word: got %b expected none at %0t", out_word, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", out_word, e.word);
                  chk("last", last, e.last);
                  chk("ones_count", $countones(out_word), e.k);
                  if (last) chk("last_word", out_word, last_tbl[e.k]);
               end
               if (sweep_on != 0) seen[out_word]++;
            end
            edn   = hs && last;
            pv    = out_valid;
            pw    = out_word;
            plast = last;
            phs   = hs;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ok;
      for (int i = 0; i < 128; i++) seen[i] = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_word", out_word, 0);
      chk("rst_last", last, 0);
      chk("rst_done", done, 0);

      rdy_mode = 0;
      run_k(0, 1'b0);
      @(negedge clk);
      chk("idle_after_k0", busy, 0);

      run_k(1, 1'b0);

      rdy_mode = 1;
      run_k(3, 1'b0);
      rdy_mode = 0;

      run_k(7, 1'b1);
      repeat (3) @(negedge clk);
      chk("idle_after_k7", busy, 0);

      sweep_on = 1;
      for (int k = 0; k < 8; k++) run_k(k, 1'b0);
      sweep_on = 0;
      for (int v = 0; v < 128; v++) chk($sformatf("cover_%0d", v), seen[v], 1);

      // abandon a k=4 sequence while a word is held
      rdy_mode = 2;
      @(negedge clk);
      count = 3'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ok = 0;
      for (int n = 0; n < 100 && ok == 0; n++) begin
         @(negedge clk);
         if (out_valid) ok = 1;
      end
      chk("k4_hold_reached", ok, 1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_word", out_word, 0);
      chk("arst_last", last, 0);
      chk("arst_done", done, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 0;
      repeat (5) @(negedge clk);
      chk("post_rst_idle", busy, 0);
      run_k(2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
